// File: rtl/fir_pkg.sv
// Shared constants and FSM state type for the 8-tap sequential FIR MAC engine.
package fir_pkg;

    localparam int TAPS       = 8;
    localparam int ADDR_WIDTH = 3;

    // Three guard bits cover the sum of eight full-precision products.
    function automatic int acc_width(input int data_w, input int coeff_w);
        return data_w + coeff_w + 3;
    endfunction

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        LAST = 2'd2,
        OUT  = 2'd3
    } fir_state_t;

endpackage

// File: rtl/fir_delay_line.sv
// Sample delay line: TAPS stages, x[0] newest, shifts on shift_en, all taps exposed flat.
module fir_delay_line
    import fir_pkg::*;
#(
    parameter int data_width = 8
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           shift_en,
    input  logic [data_width-1:0]          din,
    output logic [TAPS*data_width-1:0]     taps
);

    logic [TAPS*data_width-1:0] taps_q, taps_d;

    always_comb begin
        taps_d = taps_q;
        if (shift_en) begin
            taps_d = {taps_q[(TAPS-1)*data_width-1:0], din};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            taps_q <= '0;
        end else begin
            taps_q <= taps_d;
        end
    end

    assign taps = taps_q;

endmodule

// File: rtl/fir_mac.sv
// Sequential 8-tap FIR multiply-accumulate engine reading coefficients from a registered ROM.
// Optional output clamping is enabled by defining FIR_MAC_SAT_EN; otherwise the result wraps.
module fir_mac
    import fir_pkg::*;
#(
    parameter int data_width  = 8,
    parameter int coeff_width = 8,
    parameter int out_width   = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [data_width-1:0]  in_data,
    output logic                   rom_en,
    output logic [ADDR_WIDTH-1:0]  rom_addr,
    input  logic [coeff_width-1:0] rom_out,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [out_width-1:0]   out_data,
    output logic [1:0]             dbg_state
);

    localparam int ACC_W  = acc_width(data_width, coeff_width);
    localparam int PROD_W = data_width + coeff_width;

    // Handshakes: a transfer happens on a rising edge where valid && ready; valid and
    // payload are held stable by the sender until that edge, ready may depend on state only.

    fir_state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0]     cnt_q, cnt_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic [out_width-1:0]      out_q, out_d;

    logic                      shift_en;
    logic [TAPS*data_width-1:0] taps;
    logic [ADDR_WIDTH-1:0]     sel;
    logic signed [data_width-1:0]  x_sel;
    logic signed [PROD_W-1:0]  prod;
    logic signed [ACC_W-1:0]   acc_sum;
    logic [out_width-1:0]      result;

    fir_delay_line #(.data_width(data_width)) u_delay (
        .clock    (clock),
        .reset    (reset),
        .shift_en (shift_en),
        .din      (in_data),
        .taps     (taps)
    );

    // ROM data lags the address by one cycle; in LAST the counter has wrapped to 0, so sel = 7.
    assign sel     = cnt_q - 1'b1;
    assign x_sel   = taps[sel*data_width +: data_width];
    assign prod    = x_sel * $signed(rom_out);
    assign acc_sum = acc_q + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};

`ifdef FIR_MAC_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((64'sd1 <<< (out_width-1)) - 64'sd1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(64'sd1 <<< (out_width-1)));

    always_comb begin
        result = acc_sum[out_width-1:0];
        if (acc_sum > SAT_MAX) begin
            result = SAT_MAX[out_width-1:0];
        end else if (acc_sum < SAT_MIN) begin
            result = SAT_MIN[out_width-1:0];
        end
    end
`else
    assign result = acc_sum[out_width-1:0];
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        out_d     = out_q;
        shift_en  = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        rom_en    = 1'b0;
        rom_addr  = '0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    shift_en = 1'b1;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                rom_en   = 1'b1;
                rom_addr = cnt_q;
                if (cnt_q != '0) begin
                    acc_d = acc_sum;
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == ADDR_WIDTH'(TAPS-1)) begin
                    state_d = LAST;
                end
            end
            LAST: begin
                acc_d   = acc_sum;
                out_d   = result;
                state_d = OUT;
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            out_q   <= out_d;
        end
    end

    assign out_data  = out_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_fir_mac.sv
// Directed self-checking bench for fir_mac against a registered coefficient ROM model.
module tb_fir_mac;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        rom_en;
    logic [2:0]  rom_addr;
    logic [7:0]  rom_out;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [1:0]  dbg_state;

    logic [7:0]  rom_mem [8];
    logic        tr_en   [16];
    logic [2:0]  tr_addr [16];

    int n_tests = 0;
    int n_fail  = 0;

    fir_mac #(.data_width(8), .coeff_width(8), .out_width(16)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .rom_en    (rom_en),
        .rom_addr  (rom_addr),
        .rom_out   (rom_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .dbg_state (dbg_state)
    );

    // Clock and registered ROM model
    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (rom_en) rom_out <= rom_mem[rom_addr];
    end

    // Driver tasks
    task automatic load_rom_a();
        for (int i = 0; i < 8; i++) rom_mem[i] = 8'(8 - i);
    endtask

    task automatic load_rom_b();
        for (int i = 0; i < 8; i++) rom_mem[i] = 8'h80;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic drive_sample(input logic [7:0] d, output bit ok);
        int guard = 0;
        @(negedge clock);
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && guard < 50) begin
            @(negedge clock);
            guard++;
        end
        ok = in_ready;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        in_data  = 8'h00;
    endtask

    task automatic get_result(output logic [15:0] d, output int lat, output bit ok);
        int n = 1;
        ok  = 1'b0;
        d   = '0;
        lat = 0;
        while (n < 40) begin
            @(negedge clock);
            if (n < 16) begin
                tr_en[n]   = rom_en;
                tr_addr[n] = rom_addr;
            end
            if (out_valid) begin
                d   = out_data;
                lat = n;
                ok  = 1'b1;
                break;
            end
            @(posedge clock);
            n++;
        end
        if (ok) begin
            out_ready = 1'b1;
            @(posedge clock);
            #1;
            out_ready = 1'b0;
        end
    endtask

    // Scenario tasks
    task automatic test_reset();
        do_reset();
        n_tests++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        n_tests++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        n_tests++;
        if (out_data !== 16'h0000) begin n_fail++; $display("FAIL reset_out_data got=%h exp=0000", out_data); end
        n_tests++;
        if (rom_en !== 1'b0) begin n_fail++; $display("FAIL reset_rom_en got=%b exp=0", rom_en); end
        n_tests++;
        if (rom_addr !== 3'd0) begin n_fail++; $display("FAIL reset_rom_addr got=%0d exp=0", rom_addr); end
        n_tests++;
        if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
    endtask

    task automatic test_impulse();
        logic [15:0] d;
        int lat;
        bit ok_in, ok_out;
        load_rom_a();
        for (int i = 0; i < 9; i++) begin
            drive_sample((i == 0) ? 8'd1 : 8'd0, ok_in);
            get_result(d, lat, ok_out);
            n_tests++;
            if (!ok_in || !ok_out) begin
                n_fail++;
                $display("FAIL impulse_timeout idx=%0d in_ok=%0b out_ok=%0b exp=1,1", i, ok_in, ok_out);
            end
            n_tests++;
            if (d !== 16'(8 - i)) begin n_fail++; $display("FAIL impulse_data idx=%0d got=%0d exp=%0d", i, d, 8 - i); end
            n_tests++;
            if (lat !== 10) begin n_fail++; $display("FAIL impulse_latency idx=%0d got=%0d exp=10", i, lat); end
        end
    endtask

    task automatic test_step();
        int exp_y [9] = '{8, 15, 21, 26, 30, 33, 35, 36, 36};
        logic [15:0] d;
        int lat;
        bit ok_in, ok_out;
        load_rom_a();
        for (int i = 0; i < 9; i++) begin
            drive_sample(8'd1, ok_in);
            get_result(d, lat, ok_out);
            n_tests++;
            if (!ok_in || !ok_out || d !== 16'(exp_y[i])) begin
                n_fail++;
                $display("FAIL step_data idx=%0d got=%0d exp=%0d ok=%0b%0b", i, d, exp_y[i], ok_in, ok_out);
            end
            if (i == 0) begin
                for (int c = 1; c <= 10; c++) begin
                    n_tests++;
                    if (tr_en[c] !== (c <= 8) || tr_addr[c] !== ((c <= 8) ? 3'(c - 1) : 3'd0)) begin
                        n_fail++;
                        $display("FAIL step_rom_seq cycle=%0d got en=%b addr=%0d exp en=%0d addr=%0d",
                                 c, tr_en[c], tr_addr[c], (c <= 8), (c <= 8) ? c - 1 : 0);
                    end
                end
            end
        end
    endtask

    task automatic test_overflow();
        logic [15:0] d;
        logic [15:0] exp_2nd, exp_8th;
        int lat;
        bit ok_in, ok_out;
`ifdef FIR_MAC_SAT_EN
        exp_2nd = 16'h7fff;
        exp_8th = 16'h7fff;
`else
        exp_2nd = 16'h8000;
        exp_8th = 16'h0000;
`endif
        do_reset();
        load_rom_b();
        for (int i = 0; i < 8; i++) begin
            drive_sample(8'h80, ok_in);
            get_result(d, lat, ok_out);
            if (i == 0) begin
                n_tests++;
                if (!ok_in || !ok_out || d !== 16'd16384) begin n_fail++; $display("FAIL ovf_first got=%0d exp=16384", d); end
            end else if (i == 1) begin
                n_tests++;
                if (!ok_in || !ok_out || d !== exp_2nd) begin n_fail++; $display("FAIL ovf_second got=%h exp=%h", d, exp_2nd); end
            end else if (i == 7) begin
                n_tests++;
                if (!ok_in || !ok_out || d !== exp_8th) begin n_fail++; $display("FAIL ovf_eighth got=%h exp=%h", d, exp_8th); end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] d;
        int lat;
        int guard = 0;
        bit ok_in, ok_out;
        do_reset();
        load_rom_a();
        drive_sample(8'd3, ok_in);
        @(negedge clock);
        while (!out_valid && guard < 40) begin
            @(negedge clock);
            guard++;
        end
        n_tests++;
        if (!ok_in || !out_valid) begin n_fail++; $display("FAIL bp_timeout got valid=%b exp=1", out_valid); end
        in_valid = 1'b1;
        in_data  = 8'd99;
        for (int c = 0; c < 5; c++) begin
            n_tests++;
            if (out_valid !== 1'b1 || out_data !== 16'd24 || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold cycle=%0d got valid=%b data=%0d in_ready=%b exp 1,24,0",
                         c, out_valid, out_data, in_ready);
            end
            @(negedge clock);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        out_ready = 1'b0;
        @(negedge clock);
        n_tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_release got in_ready=%b valid=%b exp 1,0", in_ready, out_valid);
        end
        // x = {0, 3, 0...}: the offered 99 must not have entered the delay line.
        drive_sample(8'd0, ok_in);
        get_result(d, lat, ok_out);
        n_tests++;
        if (!ok_in || !ok_out || d !== 16'd21) begin n_fail++; $display("FAIL bp_not_consumed got=%0d exp=21", d); end
    endtask

    task automatic test_reset_mid_run();
        logic [15:0] d;
        int lat;
        bit ok_in, ok_out;
        load_rom_a();
        drive_sample(8'd5, ok_in);
        repeat (4) @(negedge clock);
        n_tests++;
        if (!ok_in || rom_en !== 1'b1 || rom_addr !== 3'd3) begin
            n_fail++;
            $display("FAIL mid_run_active got en=%b addr=%0d exp 1,3", rom_en, rom_addr);
        end
        reset = 1'b1;
        #1;
        n_tests++;
        if (rom_en !== 1'b0 || rom_addr !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_run_reset got en=%b addr=%0d valid=%b in_ready=%b exp 0,0,0,1",
                     rom_en, rom_addr, out_valid, in_ready);
        end
        @(negedge clock);
        reset = 1'b0;
        drive_sample(8'd1, ok_in);
        get_result(d, lat, ok_out);
        n_tests++;
        if (!ok_in || !ok_out || d !== 16'd8) begin n_fail++; $display("FAIL mid_run_after got=%0d exp=8", d); end
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) rom_mem[i] = 8'h00;
        test_reset();
        test_impulse();
        test_step();
        test_overflow();
        test_backpressure();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
